peri_axi_master: RTL and testbench

Single-outstanding AXI initiator that drives the peripheral subsystem's 64-bit AXI subordinate port. A simple command/response front end on valid/ready accepts one read or write at a time and issues it as a single-beat AXI transaction. The block checks the response and returns data and status to the requester. It sits between a control CPU or sequencer and the peripheral subsystem, on the same clock.

---
 rtl/peri_axi_master_if.sv | 65 ++++++
 rtl/peri_axi_master.sv | 103 ++++++++++
 tb/tb_peri_axi_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peri_axi_master_if.sv
// peri_axi_master_if: command/response front end plus single-beat AXI initiator bus.
interface peri_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8
);
    logic                  cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;
    logic                  rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_resp;
    logic [ADDR_W-1:0]     axi_awaddr;
    logic [3:0]            axi_awlen, axi_awcache;
    logic [2:0]            axi_awsize, axi_awprot;
    logic [1:0]            axi_awburst;
    logic                  axi_awlock, axi_awvalid, axi_awready;
    logic [DATA_W-1:0]     axi_wdata;
    logic [DATA_W/8-1:0]   axi_wstrb;
    logic                  axi_wlast, axi_wvalid, axi_wready;
    logic [ID_W-1:0]       axi_bid;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid, axi_bready;
    logic [ID_W-1:0]       axi_arid;
    logic [ADDR_W-1:0]     axi_araddr;
    logic [3:0]            axi_arlen, axi_arcache;
    logic [2:0]            axi_arsize, axi_arprot;
    logic [1:0]            axi_arburst;
    logic                  axi_arlock, axi_arvalid, axi_arready;
    logic [ID_W-1:0]       axi_rid;
    logic [DATA_W-1:0]     axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast, axi_rvalid, axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err,
        output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err,
        input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/peri_axi_master.sv
// peri_axi_master: single-outstanding command/response front end issuing single-beat 64-bit AXI transactions.
module peri_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8
) (
    input logic acr_clk,
    input logic acr_rst,
    peri_axi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t          state, state_nxt;
    logic            aw_done, w_done;
    logic [ID_W-1:0] rd_id;
    logic            accept, unaligned, aw_fire, w_fire;
    logic            unused_bid;

    assign accept     = bus.cmd_valid & bus.cmd_ready;
    assign unaligned  = |bus.cmd_addr[2:0];
    assign aw_fire    = bus.axi_awvalid & bus.axi_awready;
    assign w_fire     = bus.axi_wvalid & bus.axi_wready;
    assign unused_bid = ^bus.axi_bid;

    always_ff @(posedge acr_clk) begin
        if (acr_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = unaligned ? RSP : bus.cmd_write ? WR : RD_AR;
            WR:      if ((aw_done | aw_fire) & (w_done | w_fire)) state_nxt = WR_B;
            WR_B:    if (bus.axi_bvalid) state_nxt = RSP;
            RD_AR:   if (bus.axi_arready) state_nxt = RD_R;
            RD_R:    if (bus.axi_rvalid) state_nxt = RSP;
            RSP:     if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready   = (state == IDLE) & ~acr_rst;
        bus.axi_awvalid = (state == WR) & ~aw_done;
        bus.axi_wvalid  = (state == WR) & ~w_done;
        bus.axi_bready  = state == WR_B;
        bus.axi_arvalid = state == RD_AR;
        bus.axi_rready  = state == RD_R;
        bus.rsp_valid   = state == RSP;
        bus.axi_arid    = rd_id;
        bus.axi_awlen   = 4'd0;
        bus.axi_arlen   = 4'd0;
        bus.axi_awsize  = 3'b011;
        bus.axi_arsize  = 3'b011;
        bus.axi_awburst = 2'b01;
        bus.axi_arburst = 2'b01;
        bus.axi_awlock  = 1'b0;
        bus.axi_arlock  = 1'b0;
        bus.axi_awcache = 4'b0000;
        bus.axi_arcache = 4'b0000;
        bus.axi_awprot  = 3'b000;
        bus.axi_arprot  = 3'b000;
        bus.axi_wlast   = 1'b1;
    end

    // Per-channel done flags let AW and W complete in either order or together.
    always_ff @(posedge acr_clk) begin
        if (acr_rst) begin
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            rd_id          <= '0;
            bus.axi_awaddr <= {ADDR_W{1'b0}};
            bus.axi_araddr <= {ADDR_W{1'b0}};
            bus.axi_wdata  <= {DATA_W{1'b0}};
            bus.axi_wstrb  <= '0;
            bus.rsp_rdata  <= {DATA_W{1'b0}};
            bus.rsp_resp   <= 2'b00;
            bus.rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                aw_done        <= 1'b0;
                w_done         <= 1'b0;
                bus.axi_awaddr <= bus.cmd_addr;
                bus.axi_araddr <= bus.cmd_addr;
                bus.axi_wdata  <= bus.cmd_wdata;
                bus.axi_wstrb  <= bus.cmd_wstrb;
                bus.rsp_rdata  <= {DATA_W{1'b0}};
                bus.rsp_resp   <= unaligned ? 2'b10 : 2'b00;
                bus.rsp_err    <= unaligned;
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire) w_done <= 1'b1;
            if (state == WR_B && bus.axi_bvalid) bus.rsp_resp <= bus.axi_bresp;
            if (state == RD_R && bus.axi_rvalid) begin
                bus.rsp_rdata <= bus.axi_rdata;
                bus.rsp_resp  <= bus.axi_rresp;
                bus.rsp_err   <= ~bus.axi_rlast | (bus.axi_rid != rd_id);
                rd_id         <= rd_id + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_peri_axi_master.sv
// tb_peri_axi_master: randomized AXI subordinate with a queue scoreboard and an order-based reference model.
module tb_peri_axi_master;
    typedef struct { logic [31:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } wr_t;
    typedef struct { logic [31:0] addr; logic [7:0] id; } ar_t;
    typedef struct { logic [1:0] bresp; logic [63:0] rdata; logic [1:0] rresp; logic [7:0] rid; logic rlast; } plan_t;
    typedef struct { logic [63:0] rdata; logic [1:0] resp; logic err; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    peri_axi_master_if bus();
    peri_axi_master dut (.acr_clk(clk), .acr_rst(rst), .bus(bus));

    int compared = 0, mismatched = 0;
    int cyc = 0, acc_cyc, aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc, r_hs_cyc, rsp_first_cyc, aw_vcyc, w_vcyc;
    int k_aw = 0, k_w = 0, k_b = 0, k_ar = 0, k_r = 0, rsp_stall = 0;
    bit rsp_hold = 0;
    logic [7:0] exp_id = 8'd0;
    wr_t wr_q[$];
    ar_t ar_q[$];
    plan_t plan_q[$];
    rsp_t rsp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] outs();
        return 256'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_bready, bus.axi_rready,
                     bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.rsp_rdata, bus.rsp_resp,
                     bus.axi_awaddr, bus.axi_araddr, bus.axi_wdata, bus.axi_wstrb, bus.axi_arid});
    endfunction

    function automatic plan_t rplan(input bit bad);
        plan_t p;
        p.bresp = 2'($urandom);
        p.rdata = {$urandom, $urandom};
        p.rresp = 2'($urandom);
        p.rid   = bad ? exp_id ^ 8'(1 + $urandom_range(254)) : exp_id;
        p.rlast = bad ? 1'($urandom) : 1'b1;
        return p;
    endfunction

    // Subordinate: per-channel ready delays, responses taken in order from plan_q.
    initial begin
        bit aw_act, w_act, ar_act, aw_seen, w_seen, b_pend, r_pend;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_vc, w_vc;
        plan_t p;
        {bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_arready, bus.axi_rvalid, bus.axi_rlast} = '0;
        {bus.axi_bid, bus.axi_bresp, bus.axi_rid, bus.axi_rdata, bus.axi_rresp} = '0;
        {aw_act, w_act, ar_act, aw_seen, w_seen, b_pend, r_pend} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_vc, w_vc} = '0;
        p = '{default: '0};
        forever begin
            @(negedge clk);
            {bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_bvalid, bus.axi_rvalid} = '0;
            if (rst) begin
                {aw_act, w_act, ar_act, aw_seen, w_seen, b_pend, r_pend} = '0;
                continue;
            end
            if (bus.axi_bready) chk("bready_early", 256'(b_pend), 256'(1));
            if (b_pend) begin
                if (b_cnt > 0) b_cnt--;
                else begin
                    bus.axi_bvalid = 1'b1;
                    bus.axi_bresp  = p.bresp;
                    if (bus.axi_bready) begin b_pend = 0; b_hs_cyc = cyc; end
                end
            end
            if (bus.axi_rready) chk("rready_early", 256'(r_pend), 256'(1));
            if (r_pend) begin
                if (r_cnt > 0) r_cnt--;
                else begin
                    bus.axi_rvalid = 1'b1;
                    {bus.axi_rid, bus.axi_rdata, bus.axi_rresp, bus.axi_rlast} = {p.rid, p.rdata, p.rresp, p.rlast};
                    if (bus.axi_rready) begin r_pend = 0; r_hs_cyc = cyc; end
                end
            end
            if (aw_act) chk("awvalid_held", 256'(bus.axi_awvalid), 256'(1));
            if (bus.axi_awvalid) begin
                chk("aw_expected", 256'(wr_q.size() != 0 && !aw_seen), 256'(1));
                if (!aw_act) begin aw_act = 1; aw_cnt = k_aw; aw_vc = 0; end
                aw_vc++;
                if (aw_cnt > 0) aw_cnt--;
                else if (wr_q.size() != 0 && !aw_seen) begin
                    bus.axi_awready = 1'b1;
                    aw_act = 0; aw_seen = 1; aw_vcyc = aw_vc; aw_hs_cyc = cyc;
                    chk("awaddr", 256'(bus.axi_awaddr), 256'(wr_q[0].addr));
                    chk("aw_const", 256'({bus.axi_awlen, bus.axi_awsize, bus.axi_awburst, bus.axi_awlock, bus.axi_awcache, bus.axi_awprot}),
                        256'({4'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0}));
                end
            end
            if (w_act) chk("wvalid_held", 256'(bus.axi_wvalid), 256'(1));
            if (bus.axi_wvalid) begin
                chk("w_expected", 256'(wr_q.size() != 0 && !w_seen), 256'(1));
                if (!w_act) begin w_act = 1; w_cnt = k_w; w_vc = 0; end
                w_vc++;
                if (w_cnt > 0) w_cnt--;
                else if (wr_q.size() != 0 && !w_seen) begin
                    bus.axi_wready = 1'b1;
                    w_act = 0; w_seen = 1; w_vcyc = w_vc; w_hs_cyc = cyc;
                    chk("wbeat", 256'({bus.axi_wdata, bus.axi_wstrb, bus.axi_wlast}), 256'({wr_q[0].wdata, wr_q[0].wstrb, 1'b1}));
                end
            end
            if (aw_seen && w_seen) begin
                aw_seen = 0; w_seen = 0;
                wr_q.delete(0);
                if (plan_q.size() != 0) begin
                    p = plan_q.pop_front();
                    b_pend = 1; b_cnt = k_b; bus.axi_bid = 8'($urandom);
                end
            end
            if (ar_act) chk("arvalid_held", 256'(bus.axi_arvalid), 256'(1));
            if (bus.axi_arvalid) begin
                chk("ar_expected", 256'(ar_q.size() != 0), 256'(1));
                if (!ar_act) begin ar_act = 1; ar_cnt = k_ar; end
                if (ar_cnt > 0) ar_cnt--;
                else if (ar_q.size() != 0) begin
                    bus.axi_arready = 1'b1;
                    ar_act = 0; ar_hs_cyc = cyc;
                    chk("araddr", 256'(bus.axi_araddr), 256'(ar_q[0].addr));
                    chk("arid", 256'(bus.axi_arid), 256'(ar_q[0].id));
                    chk("ar_const", 256'({bus.axi_arlen, bus.axi_arsize, bus.axi_arburst, bus.axi_arlock, bus.axi_arcache, bus.axi_arprot}),
                        256'({4'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0}));
                    ar_q.delete(0);
                    if (plan_q.size() != 0) begin p = plan_q.pop_front(); r_pend = 1; r_cnt = k_r; end
                end
            end
        end
    end

    // Response monitor: compares every cycle rsp_valid is up, pops on handshake.
    initial begin
        bit pending = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_q.delete();
                pending = 0;
                bus.rsp_ready = 1'b0;
                continue;
            end
            bus.rsp_ready = !rsp_hold && ($urandom_range(99) >= rsp_stall);
            if (bus.rsp_valid) begin
                if (!pending) rsp_first_cyc = cyc;
                chk("cmd_ready_in_rsp", 256'(bus.cmd_ready), 256'(0));
                chk("rsp_expected", 256'(rsp_q.size() != 0), 256'(1));
                if (rsp_q.size() != 0) begin
                    chk("rsp", 256'({bus.rsp_rdata, bus.rsp_resp, bus.rsp_err}),
                        256'({rsp_q[0].rdata, rsp_q[0].resp, rsp_q[0].err}));
                    if (bus.rsp_ready) rsp_q.delete(0);
                end
            end
            pending = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws, input plan_t p);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_timeout", 256'(bus.cmd_ready), 256'(1));
            return;
        end
        {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb} = {1'b1, wr, addr, wd, ws};
        acc_cyc = cyc;
        if (addr[2:0] != 3'd0) rsp_q.push_back('{64'd0, 2'b10, 1'b1});
        else if (wr) begin
            wr_q.push_back('{addr, wd, ws});
            plan_q.push_back(p);
            rsp_q.push_back('{64'd0, p.bresp, 1'b0});
        end else begin
            ar_q.push_back('{addr, exp_id});
            plan_q.push_back(p);
            rsp_q.push_back('{p.rdata, p.rresp, !p.rlast || p.rid != exp_id});
            exp_id++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() + wr_q.size() + ar_q.size()) != 0 && n < 4000) begin @(negedge clk); n++; end
        chk("idle_timeout", 256'(rsp_q.size() + wr_q.size() + ar_q.size()), 256'(0));
    endtask

    initial begin
        plan_t p;
        logic [31:0] a;
        int kind, n;
        {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb} = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", 256'(bus.cmd_ready), 256'(1));

        p = rplan(0); p.bresp = 2'b00;
        issue(1, 32'h1000_0008, 64'hDEAD_BEEF_0123_4567, 8'hFF, p);
        wait_idle();
        chk("wr_aw_lat", 256'(aw_hs_cyc - acc_cyc), 256'(1));
        chk("wr_w_lat", 256'(w_hs_cyc - acc_cyc), 256'(1));
        chk("wr_b_lat", 256'(b_hs_cyc - acc_cyc), 256'(2));
        chk("wr_rsp_lat", 256'(rsp_first_cyc - acc_cyc), 256'(3));

        k_aw = 3;
        issue(1, 32'h2000_0010, {$urandom, $urandom}, 8'h0F, rplan(0));
        wait_idle();
        chk("aw_held_cycles", 256'(aw_vcyc), 256'(4));
        chk("w_held_cycles", 256'(w_vcyc), 256'(1));
        k_aw = 0;

        for (int i = 0; i < 3; i++) begin
            p = rplan(0); p.rdata = 64'h55AA;
            if (i == 2) p.rid = 8'd7;
            issue(0, 32'h3000_0000 + 32'(i * 8), 64'd0, 8'd0, p);
            wait_idle();
            if (i == 0) begin
                chk("rd_ar_lat", 256'(ar_hs_cyc - acc_cyc), 256'(1));
                chk("rd_r_lat", 256'(r_hs_cyc - acc_cyc), 256'(2));
                chk("rd_rsp_lat", 256'(rsp_first_cyc - acc_cyc), 256'(3));
            end
        end

        p = rplan(0); p.rlast = 1'b0; p.rresp = 2'b10;
        issue(0, 32'h3000_0100, 64'd0, 8'd0, p);
        wait_idle();

        rsp_hold = 1;
        issue(0, 32'h0000_0004, 64'd0, 8'd0, rplan(0));
        repeat (5) @(negedge clk);
        chk("unaligned_rsp_lat", 256'(rsp_first_cyc - acc_cyc), 256'(1));
        rsp_hold = 0;
        wait_idle();
        issue(1, 32'h0000_0013, {$urandom, $urandom}, 8'hFF, rplan(0));
        wait_idle();

        k_b = 50;
        issue(1, 32'h4000_0000, {$urandom, $urandom}, 8'hFF, rplan(0));
        n = 0;
        while (!bus.axi_bready && n < 100) begin @(negedge clk); n++; end
        chk("reached_wr_b", 256'(bus.axi_bready), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_wr_b", outs(), 256'(0));
        wr_q.delete(); ar_q.delete(); plan_q.delete(); rsp_q.delete();
        exp_id = 8'd0;
        k_b = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst_pulse", 256'(bus.cmd_ready), 256'(1));
        issue(0, 32'h5000_0000, 64'd0, 8'd0, rplan(0));
        wait_idle();

        for (int i = 0; i < 260; i++) begin
            a = $urandom; a[2:0] = 3'd0;
            issue(0, a, 64'd0, 8'd0, rplan(0));
        end
        wait_idle();

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(99);
            a = $urandom;
            a[2:0] = (kind < 10) ? 3'($urandom_range(7, 1)) : 3'd0;
            k_aw = $urandom_range(3); k_w = $urandom_range(3); k_b = $urandom_range(3);
            k_ar = $urandom_range(3); k_r = $urandom_range(3);
            rsp_stall = $urandom_range(60);
            issue(kind < 55, a, {$urandom, $urandom}, 8'($urandom), rplan($urandom_range(3) == 0));
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        mismatched++;
        $display("FAIL watchdog: got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end
endmodule
